// File: rtl/iterative_booth_mul.sv
// -----------------------------------------------------------------------------
// iterative_booth_mul
//
// Iterative radix-4 Booth multiplier with valid/ready handshakes on both sides.
// Each request computes the full 2*WIDTH product over WIDTH/2+1 enabled clock
// edges and returns either the low half (MUL) or the high half (MULH, MULHSU,
// MULHU). Only one operation is in flight at a time.
//
// Optional feature macro: MGT01_MUL_ZERO_BYPASS_EN
//   When defined, a request with a zero operand skips COMPUTE. It moves to DONE
//   on the accepting edge and returns 0.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_n_i      : synchronous active-low reset, overrides clk_en_i
//   clk_en_i     : all registers hold while low; handshakes do not count
//   valid_i      : request valid
//   ready_o      : request accepted when valid_i & ready_o & clk_en_i
//   op_i         : 00 MUL, 01 MULH (s x s), 10 MULHSU (s x u), 11 MULHU (u x u)
//   operand_a_i  : multiplicand
//   operand_b_i  : multiplier
//   valid_o      : result valid
//   ready_i      : result consumed when valid_o & ready_i & clk_en_i
//   result_o     : selected product half, 0 outside DONE
//   fu_state_o   : FREE when idle, BUSY otherwise
// -----------------------------------------------------------------------------
package iterative_booth_mul_pkg;
  typedef enum logic {FREE = 1'b0, BUSY = 1'b1} fu_state_e;
endpackage

module iterative_booth_mul
  import iterative_booth_mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clk_en_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output fu_state_e        fu_state_o
);

  localparam int N  = WIDTH / 2 + 1;  // Booth steps over the extended multiplier
  localparam int CW = $clog2(N + 1);
  localparam int XW = WIDTH + 2;      // extended operand width
  localparam int AW = WIDTH + 3;      // partial-product accumulator width

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      op_q;
  logic [XW-1:0]   mcand_q;
  logic [XW-1:0]   mlr_q;    // multiplier; product low bits shift in from the top
  logic [AW-1:0]   acc_q;
  logic            last_q;   // multiplier bit shifted out by the previous step

  logic            accept;
  logic            out_ack;
  logic            step_last;
  logic            zero_bypass;
  logic            a_signed, b_signed;
  logic [XW-1:0]   ext_a, ext_b;
  logic [AW-1:0]   mcand_x, pp, sum;
  logic [AW+XW-1:0] shifted;
  logic [2*WIDTH-1:0] prod;

  assign accept    = clk_en_i & valid_i & (state_q == IDLE);
  assign out_ack   = clk_en_i & ready_i & (state_q == DONE);
  assign step_last = (cnt_q == CW'(N - 1));

`ifdef MGT01_MUL_ZERO_BYPASS_EN
  assign zero_bypass = (operand_a_i == '0) | (operand_b_i == '0);
`else
  assign zero_bypass = 1'b0;
`endif

  // Operand a is signed for MUL/MULH/MULHSU, operand b for MUL/MULH. The low
  // half of MUL does not depend on signedness.
  assign a_signed = (op_i != 2'b11);
  assign b_signed = ~op_i[1];
  assign ext_a    = {{2{a_signed & operand_a_i[WIDTH-1]}}, operand_a_i};
  assign ext_b    = {{2{b_signed & operand_b_i[WIDTH-1]}}, operand_b_i};

  // Radix-4 Booth recoding of {b[1:0], last} into 0, +-A, +-2A.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pp      = '0;
    mcand_x = {mcand_q[XW-1], mcand_q};
    unique case ({mlr_q[1:0], last_q})
      3'b001, 3'b010: pp = mcand_x;
      3'b011:         pp = mcand_x << 1;
      3'b100:         pp = -(mcand_x << 1);
      3'b101, 3'b110: pp = -mcand_x;
      default:        pp = '0;
    endcase
    sum     = acc_q + pp;
    shifted = $signed({sum, mlr_q}) >>> 2;
  end

  // After N steps {acc, mlr} holds the sign-extended product.
  assign prod = {acc_q[WIDTH-3:0], mlr_q};

  // State register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n_i)      state_q <= IDLE;
    else if (clk_en_i) state_q <= state_d;
  end

  // Next state and outputs.
  always_comb begin
    state_d    = state_q;
    ready_o    = 1'b0;
    valid_o    = 1'b0;
    result_o   = '0;
    fu_state_o = BUSY;
    unique case (state_q)
      IDLE: begin
        ready_o    = 1'b1;
        fu_state_o = FREE;
        if (accept) state_d = zero_bypass ? DONE : COMPUTE;
      end
      COMPUTE: begin
        if (clk_en_i && step_last) state_d = DONE;
      end
      DONE: begin
        valid_o  = 1'b1;
        result_o = (op_q == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        if (out_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and step counter.
  always_ff @(posedge clk_i) begin
    // NOTE: the datapath is cleared on reset so an aborted operation leaves nothing behind.
    if (!rst_n_i) begin
      cnt_q   <= '0;
      op_q    <= '0;
      mcand_q <= '0;
      mlr_q   <= '0;
      acc_q   <= '0;
      last_q  <= 1'b0;
    end else if (clk_en_i) begin
      if (accept) begin
        cnt_q   <= '0;
        op_q    <= op_i;
        mcand_q <= ext_a;
        mlr_q   <= zero_bypass ? '0 : ext_b;  // zero product on bypass
        acc_q   <= '0;
        last_q  <= 1'b0;
      end else if (state_q == COMPUTE) begin
        cnt_q  <= cnt_q + CW'(1);
        acc_q  <= shifted[AW+XW-1:XW];
        mlr_q  <= shifted[XW-1:0];
        last_q <= mlr_q[1];
      end
    end
  end

endmodule

// File: tb/tb_iterative_booth_mul.sv
// -----------------------------------------------------------------------------
// tb_iterative_booth_mul
//
// Directed bench for iterative_booth_mul at WIDTH=32. Inputs change and outputs
// are sampled on the falling edge. Latency is counted as rising edges after the
// accepting edge until valid_o is seen high (17 for a full computation; with
// MGT01_MUL_ZERO_BYPASS_EN a zero operand is already done at the accepting edge).
// -----------------------------------------------------------------------------
module tb_iterative_booth_mul;
  import iterative_booth_mul_pkg::*;

  localparam int LAT = 17;
`ifdef MGT01_MUL_ZERO_BYPASS_EN
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = LAT;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        clk_en_i;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  op_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  fu_state_e   fu_state_o;

  iterative_booth_mul #(.WIDTH(32)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .clk_en_i    (clk_en_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .op_i        (op_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .result_o    (result_o),
    .fu_state_o  (fu_state_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a request at a falling edge, let it be accepted, then wait for
  // valid_o. Leaves the result unconsumed; the caller drives ready_i.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    op_i = op; operand_a_i = a; operand_b_i = b; valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 200) begin
      @(negedge clk_i);
      lat++;
    end
    if (!valid_o) check("valid_o_timeout", 64'(valid_o), 64'd1);
    res = result_o;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t        vecs[13];
  logic [31:0] res, held;
  int          lat;
  bit          spurious;

  initial begin
    vecs[0]  = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT};
    vecs[1]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT};
    vecs[2]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT};
    vecs[3]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT};
    vecs[4]  = '{2'b00, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, LAT};
    vecs[5]  = '{2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, LAT};
    vecs[6]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, LAT};
    vecs[7]  = '{2'b11, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, LAT};
    vecs[8]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT};
    vecs[9]  = '{2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, LAT};
    vecs[10] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, LAT};
    vecs[11] = '{2'b00, 32'h0000_0000, 32'h0000_1234, 32'h0000_0000, ZLAT};
    vecs[12] = '{2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, ZLAT};

    rst_n_i = 1'b0; clk_en_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    op_i = 2'b00; operand_a_i = '0; operand_b_i = '0;
    repeat (2) @(negedge clk_i);
    check("reset_ready", 64'(ready_o), 64'd1);
    check("reset_valid", 64'(valid_o), 64'd0);
    check("reset_result", 64'(result_o), 64'd0);
    check("reset_fu_state", 64'(fu_state_o), 64'(FREE));
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Table-driven vectors, result consumed immediately.
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      @(negedge clk_i);
      check($sformatf("vec%0d_idle_after", i), 64'(ready_o), 64'd1);
    end

    // Backpressure: result held for 5 cycles; a new request is ignored.
    ready_i = 1'b0;
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, held, lat);
    check("bp_result", 64'(held), 64'h4000_0000);
    valid_i = 1'b1; op_i = 2'b11; operand_a_i = 32'h3; operand_b_i = 32'h5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check($sformatf("bp_valid_%0d", i), 64'(valid_o), 64'd1);
      check($sformatf("bp_stable_%0d", i), 64'(result_o), 64'(held));
      check($sformatf("bp_ready_%0d", i), 64'(ready_o), 64'd0);
    end
    ready_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    check("bp_after_ack_ready", 64'(ready_o), 64'd1);
    check("bp_after_ack_valid", 64'(valid_o), 64'd0);
    @(negedge clk_i);
    check("bp_no_capture", 64'(ready_o), 64'd1);

    // Clock enable low for 3 edges mid-COMPUTE.
    op_i = 2'b00; operand_a_i = 32'h7; operand_b_i = 32'hFFFF_FFFD; valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    clk_en_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("ce_frozen_busy", 64'(fu_state_o), 64'(BUSY));
    check("ce_frozen_valid", 64'(valid_o), 64'd0);
    clk_en_i = 1'b1;
    lat = 8;
    while (!valid_o && lat < 200) begin
      @(negedge clk_i);
      lat++;
    end
    check("ce_latency", 64'(lat), 64'd20);
    check("ce_result", 64'(result_o), 64'hFFFF_FFEB);
    @(negedge clk_i);

    // Reset at edge 8 of COMPUTE aborts without result.
    op_i = 2'b11; operand_a_i = 32'hFFFF_FFFF; operand_b_i = 32'hFFFF_FFFF; valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (7) @(negedge clk_i);
    rst_n_i = 1'b0;
    @(negedge clk_i);
    check("rst_mid_ready", 64'(ready_o), 64'd1);
    check("rst_mid_valid", 64'(valid_o), 64'd0);
    check("rst_mid_result", 64'(result_o), 64'd0);
    check("rst_mid_fu_state", 64'(fu_state_o), 64'(FREE));
    rst_n_i = 1'b1;
    spurious = 1'b0;
    repeat (20) begin
      @(negedge clk_i);
      if (valid_o) spurious = 1'b1;
    end
    check("rst_no_result", 64'(spurious), 64'd0);
    run_op(2'b11, 32'h3, 32'h5, res, lat);
    check("rst_then_mulhu_result", 64'(res), 64'd0);
    check("rst_then_mulhu_latency", 64'(lat), 64'(LAT));
    @(negedge clk_i);

    // Reset in DONE with clock enable low.
    ready_i = 1'b0;
    run_op(2'b00, 32'h7, 32'hFFFF_FFFD, res, lat);
    check("done_result", 64'(res), 64'hFFFF_FFEB);
    clk_en_i = 1'b0;
    rst_n_i  = 1'b0;
    @(negedge clk_i);
    check("rst_done_ce0_ready", 64'(ready_o), 64'd1);
    check("rst_done_ce0_valid", 64'(valid_o), 64'd0);
    check("rst_done_ce0_result", 64'(result_o), 64'd0);
    rst_n_i = 1'b1; clk_en_i = 1'b1; ready_i = 1'b1;
    @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
